ram_sync_dp: RTL and testbench

Dual-port synchronous RAM, parametrised in address width, data width and fill value. Port A is read/write with per-byte write enables; port B is read-only. A built-in clear sequencer sweeps the whole array to a fill value after reset and on request. It is the general-purpose block-RAM primitive for CPU data memory, video buffers and peripheral scratch space.

---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_clear_seq.sv | 60 ++++++
 rtl/ram_sync_dp.sv | 104 ++++++++++
 tb/tb_ram_sync_dp.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types for the dual-port RAM: clear-sequencer state and byte-lane helper.
package ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_t;

    // Number of 8-bit byte lanes in a data word.
    function automatic int num_lanes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: sweeps every address once after reset and after a clear
// request, then idles in READY until the next request.
//
// state | meaning
// CLEAR | sweep in progress, one address written with the fill word per clk
// READY | normal operation, port A writes allowed
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  clr_,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] sweep_addr,
    output logic                  sweep_we
);

    ram_state_t            state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  clr_pend;

    // FSM with registered busy/strobe; a request seen in READY is held one
    // cycle in clr_pend so the sweep starts on the following edge.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state    <= CLEAR;
            cnt      <= '0;
            clr_pend <= 1'b0;
            busy     <= 1'b1;
            sweep_we <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    cnt      <= cnt + 1'b1;
                    clr_pend <= 1'b0;
                    if (cnt == '1) begin
                        state    <= READY;
                        busy     <= 1'b0;
                        sweep_we <= 1'b0;
                    end
                end
                READY: begin
                    if (clr_pend) begin
                        state    <= CLEAR;
                        clr_pend <= 1'b0;
                        busy     <= 1'b1;
                        sweep_we <= 1'b1;
                    end else begin
                        clr_pend <= ~clr_;
                    end
                end
            endcase
        end
    end

    assign sweep_addr = cnt;

endmodule

// File: rtl/ram_sync_dp.sv
// Dual-port synchronous RAM: port A read/write with byte enables, port B
// read-only, built-in clear sweep to FILL_VALUE.
// Optional feature macro: RAM_DP_FWD_EN -- forwards a same-cycle port A write
// onto port B when both ports address the same word. Undefined: port B
// returns the old word on that collision.
module ram_sync_dp
    import ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
    input  logic                                clk,
    input  logic                                reset_,
    input  logic                                clr_,
    output logic                                busy,
    input  logic [ADDR_WIDTH-1:0]               a_addr,
    input  logic [DATA_WIDTH-1:0]               a_din,
    input  logic                                a_we_,
    input  logic [num_lanes(DATA_WIDTH)-1:0]    a_be,
    output logic [DATA_WIDTH-1:0]               a_dout,
    input  logic [ADDR_WIDTH-1:0]               b_addr,
    output logic [DATA_WIDTH-1:0]               b_dout
);

    localparam int NB    = num_lanes(DATA_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] sweep_addr;
    logic                  sweep_we;
    logic [DATA_WIDTH-1:0] b_rd_q;

    ram_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_seq (
        .clk        (clk),
        .reset_     (reset_),
        .clr_       (clr_),
        .busy       (busy),
        .sweep_addr (sweep_addr),
        .sweep_we   (sweep_we)
    );

    // Array write: the sweep owns the write port while it runs, otherwise
    // port A writes the enabled byte lanes. The array itself is never reset.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_addr] <= FILL_VALUE;
        end else if (!a_we_) begin
            for (int i = 0; i < NB; i++) begin
                if (a_be[i]) begin
                    mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
                end
            end
        end
    end

    // Registered read-first outputs; both ports show the fill word mid-sweep.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            a_dout <= '0;
            b_rd_q <= '0;
        end else if (busy) begin
            a_dout <= FILL_VALUE;
            b_rd_q <= FILL_VALUE;
        end else begin
            a_dout <= mem[a_addr];
            b_rd_q <= mem[b_addr];
        end
    end

`ifdef RAM_DP_FWD_EN
    logic                  fwd_hit_q;
    logic [NB-1:0]         fwd_be_q;
    logic [DATA_WIDTH-1:0] fwd_din_q;

    // Capture a same-address port A write so its lanes can override port B.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            fwd_hit_q <= 1'b0;
            fwd_be_q  <= '0;
            fwd_din_q <= '0;
        end else begin
            fwd_hit_q <= !busy && !a_we_ && (a_addr == b_addr);
            fwd_be_q  <= a_be;
            fwd_din_q <= a_din;
        end
    end

    // Per-lane merge after the read register keeps latency at one cycle.
    always_comb begin
        b_dout = b_rd_q;
        for (int i = 0; i < NB; i++) begin
            if (fwd_hit_q && fwd_be_q[i]) begin
                b_dout[8*i +: 8] = fwd_din_q[8*i +: 8];
            end
        end
    end
`else
    assign b_dout = b_rd_q;
`endif

endmodule

// File: tb/tb_ram_sync_dp.sv
// Self-checking bench for ram_sync_dp (ADDR_WIDTH=4, FILL_VALUE=16'hA5A5).
// Expected values come from a word-array model that follows the behavioural
// rules: sweep of 16 writes, read-first ports, byte-lane merge, optional
// port B forwarding under RAM_DP_FWD_EN.
module tb_ram_sync_dp;

    localparam int          AW    = 4;
    localparam int          DW    = 16;
    localparam int          DEPTH = 16;
    localparam logic [15:0] FILL  = 16'hA5A5;

    logic          clk = 1'b0;
    logic          reset_;
    logic          clr_;
    logic          busy;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din;
    logic          a_we_;
    logic [1:0]    a_be;
    logic [DW-1:0] a_dout;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_dout;

    int total = 0;
    int bad   = 0;

    logic [15:0] mm [DEPTH];
    int          left;
    bit          pend;

    ram_sync_dp #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FILL_VALUE (FILL)
    ) dut (
        .clk    (clk),
        .reset_ (reset_),
        .clr_   (clr_),
        .busy   (busy),
        .a_addr (a_addr),
        .a_din  (a_din),
        .a_we_  (a_we_),
        .a_be   (a_be),
        .a_dout (a_dout),
        .b_addr (b_addr),
        .b_dout (b_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict, take the edge, compare 1 ns later.
    task automatic step(input logic we_n, input logic [1:0] be, input logic [3:0] aa,
                        input logic [15:0] din, input logic [3:0] ba, input logic clr_n,
                        input string tag);
        logic [15:0] exp_a, exp_b, old, merged;
        a_we_  = we_n;
        a_be   = be;
        a_addr = aa;
        a_din  = din;
        b_addr = ba;
        clr_   = clr_n;
        if (left > 0) begin
            exp_a = FILL;
            exp_b = FILL;
            mm[DEPTH - left] = FILL;
            left--;
        end else begin
            old   = mm[aa];
            exp_a = old;
            exp_b = mm[ba];
            if (!we_n) begin
                merged = old;
                if (be[0]) merged[7:0]  = din[7:0];
                if (be[1]) merged[15:8] = din[15:8];
`ifdef RAM_DP_FWD_EN
                if (ba == aa) exp_b = merged;
`endif
                mm[aa] = merged;
            end
            if (pend) begin
                left = DEPTH;
                pend = 1'b0;
            end else begin
                pend = !clr_n;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, "_a"}, a_dout, exp_a);
        chk({tag, "_b"}, b_dout, exp_b);
        chk({tag, "_busy"}, {15'd0, busy}, {15'd0, left > 0});
    endtask

    task automatic idle(input string tag);
        step(1'b1, 2'b00, 4'd0, 16'h0000, 4'd0, 1'b1, tag);
    endtask

    initial begin
        logic [15:0] rd;
        reset_ = 1'b0;
        clr_   = 1'b1;
        a_we_  = 1'b1;
        a_be   = 2'b00;
        a_addr = '0;
        a_din  = '0;
        b_addr = '0;
        left   = DEPTH;
        pend   = 1'b0;
        #12;
        chk("rst_a", a_dout, 16'h0000);
        chk("rst_b", b_dout, 16'h0000);
        chk("rst_busy", {15'd0, busy}, 16'd1);

        // Power-up sweep; writes attempted meanwhile must be discarded.
        @(negedge clk);
        reset_ = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 2'b11, 4'(i), 16'h5A5A, 4'(i), 1'b1, "sweep");
        chk("sweep_done", {15'd0, busy}, 16'd0);

        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 2'b00, 4'(i), 16'h0000, 4'(15 - i), 1'b1, "fillrd");
            chk("fill_a", a_dout, 16'hA5A5);
        end

        // Byte-lane write.
        step(1'b0, 2'b11, 4'd3, 16'h1234, 4'd0, 1'b1, "bw1");
        step(1'b0, 2'b10, 4'd3, 16'hFF00, 4'd0, 1'b1, "bw2");
        step(1'b1, 2'b00, 4'd3, 16'h0000, 4'd3, 1'b1, "bwrd");
        chk("bytelane_a", a_dout, 16'hFF34);
        chk("bytelane_b", b_dout, 16'hFF34);

        // Read-first on port A.
        step(1'b0, 2'b11, 4'd5, 16'h1111, 4'd0, 1'b1, "rf1");
        step(1'b0, 2'b11, 4'd5, 16'h2222, 4'd0, 1'b1, "rf2");
        chk("readfirst_old", a_dout, 16'h1111);
        step(1'b1, 2'b00, 4'd5, 16'h0000, 4'd5, 1'b1, "rf3");
        chk("readfirst_new", a_dout, 16'h2222);

        // Same-address collision.
        step(1'b0, 2'b11, 4'd7, 16'h0F0F, 4'd0, 1'b1, "col1");
        step(1'b0, 2'b01, 4'd7, 16'hABCD, 4'd7, 1'b1, "col2");
`ifdef RAM_DP_FWD_EN
        chk("collision_b", b_dout, 16'h0FCD);
`else
        chk("collision_b", b_dout, 16'h0F0F);
`endif
        step(1'b1, 2'b00, 4'd7, 16'h0000, 4'd7, 1'b1, "col3");
        chk("collision_after", a_dout, 16'h0FCD);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            logic [3:0] aa, ba;
            aa = 4'($urandom_range(0, 15));
            ba = ($urandom_range(0, 3) == 0) ? aa : 4'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), aa,
                 16'($urandom), ba, 1'b1, "rnd");
        end

        // Clear request with a write in the same cycle; clr_ then held low
        // for part of the sweep, which must not extend it.
        step(1'b0, 2'b11, 4'd2, 16'h7777, 4'd0, 1'b0, "clr0");
        chk("clr_busy_n", {15'd0, busy}, 16'd0);
        step(1'b1, 2'b00, 4'd2, 16'h0000, 4'd0, 1'b1, "clr1");
        chk("clr_busy_n1", {15'd0, busy}, 16'd1);
        for (int i = 0; i < 10; i++)
            step(1'b1, 2'b00, 4'd0, 16'h0000, 4'd0, 1'b0, "clrhold");
        for (int i = 0; i < 6; i++)
            idle("clrrun");
        chk("clr_len", {15'd0, busy}, 16'd0);
        step(1'b1, 2'b00, 4'd2, 16'h0000, 4'd2, 1'b1, "clrrd");
        chk("clr_addr2", a_dout, 16'hA5A5);

        // Reset in the middle of a sweep, at counter 9.
        step(1'b0, 2'b11, 4'd9, 16'h3C3C, 4'd9, 1'b0, "mr0");
        idle("mr1");
        for (int i = 0; i < 9; i++)
            idle("mrsweep");
        #2;
        reset_ = 1'b0;
        #1;
        chk("midrst_a", a_dout, 16'h0000);
        chk("midrst_b", b_dout, 16'h0000);
        chk("midrst_busy", {15'd0, busy}, 16'd1);
        left = DEPTH;
        pend = 1'b0;
        @(negedge clk);
        reset_ = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            idle("resweep");
        chk("resweep_done", {15'd0, busy}, 16'd0);
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 2'b00, 4'(i), 16'h0000, 4'(i), 1'b1, "finalrd");
        rd = a_dout;
        chk("final_fill", rd, 16'hA5A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
